// File: rtl/ff_write_arbiter.sv
// ============================================================================
// ff_write_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Round-robin arbiter/sequencer that shares a single enabled D-register
//   among N_REQ requesters. One requester owns the register at a time. The
//   owner's data slice is driven onto D and written when the owner keeps its
//   request asserted. A tenure lasts at most MAX_HOLD cycles while other
//   requesters are waiting, so a continuously requesting client cannot starve
//   the others.
//
// Parameters:
//   N_REQ    number of requesters (2..8)
//   WIDTH    data width of D and Q
//   MAX_HOLD maximum consecutive granted cycles per tenure (>= 1)
//
// Optional feature (macro ARB_LOCK_EN):
//   When defined, a `lock` input lets the current owner extend its tenure
//   past MAX_HOLD. hold_cnt saturates at MAX_HOLD while the lock is held.
//   When undefined, the port does not exist and rotation is always enforced.
//
// Ports:
//   clock   in   1            system clock, rising edge
//   reset   in   1            asynchronous active-high reset
//   req     in   N_REQ        per-requester write request (bit i = requester i)
//   data    in   N_REQ*WIDTH  requester data, slice [i*WIDTH +: WIDTH]
//   lock    in   1            tenure extension (only with ARB_LOCK_EN)
//   grant   out  N_REQ        registered one-hot grant, zero when idle
//   busy    out  1            high while a requester owns the register
//   enable  out  1            write strobe = busy & req[owner]
//   D       out  WIDTH        owner's data when busy, else 0
//   Q       out  WIDTH        register contents
// ============================================================================
module ff_write_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*WIDTH-1:0]  data,
`ifdef ARB_LOCK_EN
    input  logic                    lock,
`endif
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    enable,
    output logic [WIDTH-1:0]        D,
    output logic [WIDTH-1:0]        Q
);

    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(N_REQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t              state_reg, state_next;
    logic [N_REQ-1:0]    grant_reg, grant_next;
    logic [PTR_W-1:0]    ptr_reg,   ptr_next;
    logic [HOLD_W-1:0]   hold_reg,  hold_next;
    logic [WIDTH-1:0]    q_reg;

    // ------------------------------------------------------------------------
    // Derived signals
    // ------------------------------------------------------------------------
    logic [PTR_W-1:0]    owner_idx;
    logic [PTR_W-1:0]    ptr_after_owner;
    logic                owner_req;
    logic                others_req;
    logic                hold_at_max;
    logic                lock_eff;
    logic [N_REQ-1:0]    sel_from_ptr;
    logic [N_REQ-1:0]    sel_after_owner;
    logic [WIDTH-1:0]    d_mux;

`ifdef ARB_LOCK_EN
    assign lock_eff = lock;
`else
    assign lock_eff = 1'b0;
`endif

    // Round-robin pick: first set bit of r scanning upward from base,
    // wrapping modulo N_REQ. Returns a one-hot vector, or zero if r is empty.
    function automatic logic [N_REQ-1:0] rr_pick(
        input logic [PTR_W-1:0] base,
        input logic [N_REQ-1:0] r
    );
        logic [N_REQ-1:0] pick;
        logic             found;
        int               idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(base) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && r[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

    // One-hot grant to binary owner index (grant is zero only when idle,
    // where owner_idx is never consumed).
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_reg[i]) begin
                owner_idx = PTR_W'(i);
            end
        end
    end

    assign ptr_after_owner = (owner_idx == PTR_LAST) ? '0 : owner_idx + 1'b1;
    assign owner_req       = |(req & grant_reg);
    assign others_req      = |(req & ~grant_reg);
    assign hold_at_max     = (hold_reg == HOLD_MAX);

    // Both candidate selections are computed every cycle; the FSM decides
    // which one (if any) is loaded into the grant register.
    assign sel_from_ptr    = rr_pick(ptr_reg, req);
    assign sel_after_owner = rr_pick(ptr_after_owner, req);

    // ------------------------------------------------------------------------
    // Data mux: AND-OR of the slices gated by the one-hot grant.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] slice_gated [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign slice_gated[gi] = data[gi*WIDTH +: WIDTH]
                                   & {WIDTH{grant_reg[gi]}};
        end
    endgenerate

    always_comb begin
        d_mux = '0;
        for (int i = 0; i < N_REQ; i++) begin
            d_mux = d_mux | slice_gated[i];
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        ptr_next   = ptr_reg;
        hold_next  = hold_reg;

        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next = OWN;
                    grant_next = sel_from_ptr;
                    hold_next  = HOLD_ONE;
                end
            end

            OWN: begin
                if (!owner_req) begin
                    // Owner released: pointer moves past it regardless of
                    // whether anyone else is waiting.
                    ptr_next = ptr_after_owner;
                    if (others_req) begin
                        // Hand over on the same edge, no idle bubble.
                        grant_next = sel_after_owner;
                        hold_next  = HOLD_ONE;
                    end else begin
                        state_next = IDLE;
                        grant_next = '0;
                        hold_next  = '0;
                    end
                end else if (hold_at_max && others_req && !lock_eff) begin
                    // Forced rotation. Scanning from owner+1 always reaches
                    // a waiting requester before wrapping back to the owner.
                    ptr_next   = ptr_after_owner;
                    grant_next = sel_after_owner;
                    hold_next  = HOLD_ONE;
                end else if (hold_at_max) begin
                    // Nobody waiting: tenure restarts. A locked owner instead
                    // saturates so rotation fires on the edge lock drops.
                    hold_next = lock_eff ? HOLD_MAX : HOLD_ONE;
                end else begin
                    hold_next = hold_reg + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                grant_next = '0;
                hold_next  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            ptr_reg   <= '0;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            ptr_reg   <= ptr_next;
            hold_reg  <= hold_next;
        end
    end

    // ------------------------------------------------------------------------
    // Shared storage register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_reg <= '0;
        end else if (enable) begin
            q_reg <= D;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy   = (state_reg == OWN);
    assign grant  = grant_reg;
    // A dropped request suppresses the write immediately, not at the edge.
    assign enable = busy & owner_req;
    assign D      = busy ? d_mux : '0;
    assign Q      = q_reg;

endmodule

// File: doc/ff_write_arbiter.md
Name: ff_write_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one enabled D-register, with `enable`, `D` and `Q`, among N_REQ requesters.
- Grants one requester at a time and drives that requester's data onto `D` with `enable`.
- Caps each tenure at MAX_HOLD cycles so a continuously requesting client cannot starve the others.
- Sits between requesting logic and the storage flop; the register itself is internal.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 1, data width of `D` and `Q`.
- MAX_HOLD, 4, maximum consecutive granted cycles per tenure (>=1).

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester write request; bit i belongs to requester i.
- data  input  N_REQ*WIDTH  requester data; slice [i*WIDTH +: WIDTH] belongs to requester i.
- lock  input  1  tenure-extension request from the current owner; present only with ARB_LOCK_EN.
- grant  output  N_REQ  one-hot registered grant; all-zero when idle.
- busy  output  1  high while in state OWN.
- enable  output  1  write strobe to the register.
- D  output  WIDTH  muxed data of the owner.
- Q  output  WIDTH  register contents.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-tenure):
  - state=IDLE, grant=0, busy=0, ptr=0, hold_cnt=0, Q=0.
  - enable=0 and D=0 follow combinationally.
- Combinational outputs:
  - enable = busy & req[owner].
  - D = data slice of owner when busy, else 0.
  - No write occurs if the owner has dropped req.
- Register: on a rising clock edge with enable=1, Q <= D; otherwise Q holds.
- Selection function: the first asserted req bit scanning from ptr upward, wrapping modulo N_REQ.
- State IDLE:
  - If any req bit is set, register grant to the selected requester, go to OWN, hold_cnt=1.
  - Else stay in IDLE.
- State OWN, evaluated each edge in this priority:
  - req[owner]=0: release the grant, ptr=owner+1 mod N_REQ. If any other req is set, grant the new selection the same edge (no idle bubble), hold_cnt=1. Else go to IDLE and set grant=0.
  - hold_cnt==MAX_HOLD and another req is set: forced rotation; ptr=owner+1, grant the next selection, hold_cnt=1.
  - hold_cnt==MAX_HOLD and no other req: keep the owner, hold_cnt=1 (tenure restarts).
  - Otherwise: keep the owner, hold_cnt=hold_cnt+1.
- Latency: req rises in cycle 0, grant and enable appear in cycle 1, Q shows the new data in cycle 2.
- hold_cnt is ceil(log2(MAX_HOLD+1)) bits and never exceeds MAX_HOLD.
- Simultaneous requests are resolved solely by ptr; the lowest index wins only when ptr=0.
- grant is always one-hot or zero; two bits set is an error.
- Changes on req or data between edges affect only enable and D combinationally; the grant changes only on edges.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - The `lock` port exists.
  - While in OWN with lock=1 and req[owner]=1, forced rotation at MAX_HOLD is suppressed and hold_cnt saturates at MAX_HOLD.
  - Release on a req drop is unchanged.
  - lock is ignored in IDLE and when busy=0.
- Undefined:
  - No `lock` port.
  - Rotation is always enforced as above.

Test Plan:
- Reset mid-tenure: req=4'b0010, data[1]=8'hA5; assert reset during cycle 2 -> grant, busy, enable and D go to 0 at once; Q=0; after release, arbitration restarts from ptr=0.
- Single requester: req=4'b0100, data[2]=8'h3C (WIDTH=8) from cycle 0 -> grant=4'b0100 in cycle 1, enable=1, Q=8'h3C in cycle 2; req drop -> grant=0 next edge.
- Contention: req=4'b1011 held, MAX_HOLD=4 -> grant sequence 0001 for 4 cycles, 0010 for 4, 1000 for 4, then 0001; never 0100.
- Back-to-back handover: owner 0 drops req while req[3]=1 -> grant=4'b1000 on the same edge, with no cycle of grant=0.
- Owner drops req mid-cycle: enable falls combinationally; Q unchanged at that edge.
- With ARB_LOCK_EN: req=4'b0011 and lock=1 on owner 0 for 10 cycles -> grant stays 4'b0001 for all 10; lock=0 -> rotates to 4'b0010 at the next edge (hold_cnt saturated).
